mac_seq_ctrl: RTL

MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

---
 rtl/mac_ctrl_pkg.sv | 18 +
 rtl/tap_counter.sv | 34 +++
 rtl/mac_seq_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mac_ctrl_pkg.sv
// Shared definitions for the sequenced-MAC controller.
//   - Default parameter values for operand, address and tap-count widths.
//   - Controller state encoding.
package mac_ctrl_pkg;

    localparam int DEF_INPUT_MULTIPLICAND = 16;
    localparam int DEF_ADDR_W             = 10;
    localparam int DEF_TAP_W              = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

endpackage

// File: rtl/tap_counter.sv
// Tap counter for the MAC sequencer.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   clr      : zero the count (takes priority over en)
//   en       : advance the count by one
//   last     : terminal value; tc is high while cnt equals it
//   cnt      : current tap index
//   tc       : terminal-count flag
module tap_counter #(
    parameter int W = mac_ctrl_pkg::DEF_TAP_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= cnt_reg + W'(1);
        end
    end

    assign cnt = cnt_reg;
    assign tc  = (cnt_reg == last);

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencer for one dot-product job on an external MAC.
// A job streams num_taps pixel/kernel address pairs to memory (read data
// returns one cycle after rd_en), lets the MAC accumulate exactly those
// products, then presents the accumulator on result with a valid/ready
// handshake.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   start, num_taps,
//   pix_base, ker_base       : job request, latched when accepted in IDLE
//   busy                     : high in every state except IDLE
//   rd_en, pix_addr, ker_addr: memory read strobe and addresses
//   mac_rst, mac_stop        : MAC accumulator clear and hold
//   mac_out                  : MAC accumulator value
//   result, result_valid,
//   result_ready, done       : result handshake; done pulses on acceptance
module mac_seq_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int INPUT_MULTIPLICAND = DEF_INPUT_MULTIPLICAND,
    parameter int ADDR_W             = DEF_ADDR_W,
    parameter int TAP_W              = DEF_TAP_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [TAP_W-1:0]                num_taps,
    input  logic [ADDR_W-1:0]               pix_base,
    input  logic [ADDR_W-1:0]               ker_base,
    output logic                            busy,
    output logic                            rd_en,
    output logic [ADDR_W-1:0]               pix_addr,
    output logic [ADDR_W-1:0]               ker_addr,
    output logic                            mac_rst,
    output logic                            mac_stop,
    input  logic [2*INPUT_MULTIPLICAND-1:0] mac_out,
    output logic [2*INPUT_MULTIPLICAND-1:0] result,
    output logic                            result_valid,
    input  logic                            result_ready,
    output logic                            done
);

    localparam int RES_W = 2 * INPUT_MULTIPLICAND;

    state_t              state_reg;
    logic [TAP_W-1:0]    num_taps_reg;
    logic [ADDR_W-1:0]   pix_base_reg;
    logic [ADDR_W-1:0]   ker_base_reg;
    logic [RES_W-1:0]    result_reg;
    logic                out_first_reg;
    logic                rd_en_reg;
    logic                mac_rst_reg;
    logic                mac_stop_reg;
    logic                result_valid_reg;

    logic [TAP_W-1:0]    tap_cnt;
    logic                tap_tc;

    tap_counter #(
        .W(TAP_W)
    ) u_tap_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_reg == ST_CLEAR),
        .en   (state_reg == ST_RUN),
        .last (num_taps_reg - TAP_W'(1)),
        .cnt  (tap_cnt),
        .tc   (tap_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            num_taps_reg     <= '0;
            pix_base_reg     <= '0;
            ker_base_reg     <= '0;
            result_reg       <= '0;
            out_first_reg    <= 1'b0;
            rd_en_reg        <= 1'b0;
            mac_rst_reg      <= 1'b0;
            mac_stop_reg     <= 1'b1;
            result_valid_reg <= 1'b0;
        end else begin
            // Read data is valid the cycle after rd_en, so the MAC is
            // released exactly one cycle behind each read strobe.
            mac_stop_reg <= ~rd_en_reg;
            mac_rst_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        num_taps_reg <= num_taps;
                        pix_base_reg <= pix_base;
                        ker_base_reg <= ker_base;
                        mac_rst_reg  <= 1'b1;
                        state_reg    <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (num_taps_reg != '0) begin
                        rd_en_reg <= 1'b1;
                        state_reg <= ST_RUN;
                    end else begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_RUN: begin
                    if (tap_tc) begin
                        rd_en_reg <= 1'b0;
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    result_valid_reg <= 1'b1;
                    out_first_reg    <= 1'b1;
                    state_reg        <= ST_OUT;
                end
                ST_OUT: begin
                    out_first_reg <= 1'b0;
                    if (out_first_reg) begin
                        result_reg <= mac_out;
                    end
                    if (result_ready) begin
                        result_valid_reg <= 1'b0;
                        state_reg        <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Addresses wrap modulo 2**ADDR_W through natural truncation.
    assign pix_addr = pix_base_reg + ADDR_W'(tap_cnt);
    assign ker_addr = ker_base_reg + ADDR_W'(tap_cnt);

    // The last product lands in the accumulator on the edge that enters OUT,
    // so the first OUT cycle forwards mac_out and the capture register holds
    // it for the rest of the handshake.
    assign result = out_first_reg ? mac_out : result_reg;

    // rst gates the strobes immediately, not only after the next edge.
    assign busy         = (state_reg != ST_IDLE) & ~rst;
    assign rd_en        = rd_en_reg & ~rst;
    assign mac_rst      = mac_rst_reg | rst;
    assign mac_stop     = mac_stop_reg | rst;
    assign result_valid = result_valid_reg & ~rst;
    assign done         = result_valid & result_ready;

endmodule
